// File: rtl/ysyx_23060072_branch_verify_pkg.sv
// Shared definitions for the branch verify block: state encodings, instruction
// size, enable/disable constants and the prediction record layout.
// Optional feature macro: YSYX_23060072_BPU_PERF_EN (see top module).
package ysyx_23060072_branch_verify_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } bv_state_e;

    localparam logic [31:0] INST_SIZE = 32'd4;
    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;
    localparam int          REC_W     = 65;

    // Field order matches the queue entry layout {pc, flag, target}.
    typedef struct packed {
        logic [31:0] pc;
        logic        flag;
        logic [31:0] target;
    } pred_rec_t;

    // Next PC after an instruction: target if control transfer, else fall-through.
    function automatic logic [31:0] next_pc(input logic taken,
                                            input logic [31:0] target,
                                            input logic [31:0] pc);
        return taken ? target : pc + INST_SIZE;
    endfunction

endpackage

// File: rtl/ysyx_23060072_branch_verify_if.sv
// IF/EX-facing signal bundle of the branch verify block.
// slave = the verify block, master = the IF/EX side driving it.
// Optional feature macro: YSYX_23060072_BPU_PERF_EN adds the perf counter outputs.
interface ysyx_23060072_branch_verify_if;
    logic        pred_valid_i;
    logic        pred_ready_o;
    logic [31:0] pred_pc_i;
    logic        pred_flag_i;
    logic [31:0] pred_target_i;
    logic        res_valid_i;
    logic        res_ready_o;
    logic [31:0] res_pc_i;
    logic        res_taken_i;
    logic [31:0] res_target_i;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic        sync_err_o;
`ifdef YSYX_23060072_BPU_PERF_EN
    logic [31:0] perf_ctrl_o;
    logic [31:0] perf_miss_o;
`endif

    modport slave (
        input  pred_valid_i, pred_pc_i, pred_flag_i, pred_target_i,
        input  res_valid_i, res_pc_i, res_taken_i, res_target_i,
        output pred_ready_o, res_ready_o, redirect_o, redirect_pc_o,
        output flush_o, sync_err_o
`ifdef YSYX_23060072_BPU_PERF_EN
        , output perf_ctrl_o, perf_miss_o
`endif
    );

    modport master (
        output pred_valid_i, pred_pc_i, pred_flag_i, pred_target_i,
        output res_valid_i, res_pc_i, res_taken_i, res_target_i,
        input  pred_ready_o, res_ready_o, redirect_o, redirect_pc_o,
        input  flush_o, sync_err_o
`ifdef YSYX_23060072_BPU_PERF_EN
        , input perf_ctrl_o, perf_miss_o
`endif
    );
endinterface

// File: rtl/ysyx_23060072_pred_fifo.sv
// In-order circular queue of prediction records. Pointers carry an extra wrap
// bit so full and empty are distinguishable with all DEPTH slots usable.
module ysyx_23060072_pred_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Pointer update; clear drops every queued record at once.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
endmodule

// File: rtl/ysyx_23060072_branch_verify.sv
// Checks each IF prediction against the EX resolution and issues a registered
// redirect + flush on a wrong next-PC.
// Optional feature macro: YSYX_23060072_BPU_PERF_EN adds saturating perf counters.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | normal operation: accept predictions, consume resolutions
// ST_RECOVER | one-cycle redirect/flush pulse, both sides stalled
module ysyx_23060072_branch_verify
    import ysyx_23060072_branch_verify_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    ysyx_23060072_branch_verify_if.slave bus
);
    bv_state_e   state_q, state_d;
    pred_rec_t   head, wr_rec;
    logic        full, empty, push, pop, clr, mismatch;
    logic [31:0] pred_next, act_next, redirect_pc_q;
    logic        sync_err_q;

    assign wr_rec = '{pc: bus.pred_pc_i, flag: bus.pred_flag_i, target: bus.pred_target_i};

    ysyx_23060072_pred_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata (wr_rec),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign pred_next = next_pc(head.flag, head.target, head.pc);
    assign act_next  = next_pc(bus.res_taken_i, bus.res_target_i, bus.res_pc_i);
    assign mismatch  = (pred_next != act_next);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Next state, handshakes and queue control; a mispredict drops any same-cycle push.
    always_comb begin
        state_d          = state_q;
        bus.pred_ready_o = DISABLE;
        bus.res_ready_o  = DISABLE;
        bus.redirect_o   = DISABLE;
        bus.flush_o      = DISABLE;
        push             = DISABLE;
        pop              = DISABLE;
        clr              = DISABLE;
        case (state_q)
            ST_RUN: begin
                bus.pred_ready_o = !full;
                bus.res_ready_o  = !empty;
                pop              = bus.res_valid_i && !empty;
                if (pop && mismatch) begin
                    clr     = ENABLE;
                    state_d = ST_RECOVER;
                end
                push = bus.pred_valid_i && !full && !clr;
            end
            ST_RECOVER: begin
                bus.redirect_o = ENABLE;
                bus.flush_o    = ENABLE;
                state_d        = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Redirect target capture and sticky PC-desync flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_pc_q <= '0;
            sync_err_q    <= DISABLE;
        end else begin
            if (clr) redirect_pc_q <= act_next;
            if (pop && (bus.res_pc_i != head.pc)) sync_err_q <= ENABLE;
        end
    end

    assign bus.redirect_pc_o = redirect_pc_q;
    assign bus.sync_err_o    = sync_err_q;

`ifdef YSYX_23060072_BPU_PERF_EN
    logic [31:0] perf_ctrl_q, perf_miss_q;

    // Saturating counts of control-flow pops and mispredicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ctrl_q <= '0;
            perf_miss_q <= '0;
        end else begin
            if (pop && (head.flag || bus.res_taken_i) && (perf_ctrl_q != '1))
                perf_ctrl_q <= perf_ctrl_q + 32'd1;
            if (clr && (perf_miss_q != '1))
                perf_miss_q <= perf_miss_q + 32'd1;
        end
    end

    assign bus.perf_ctrl_o = perf_ctrl_q;
    assign bus.perf_miss_o = perf_miss_q;
`endif
endmodule

// File: tb/tb_ysyx_23060072_branch_verify.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared cycle by cycle against a queue-based reference model.
module tb_ysyx_23060072_branch_verify;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_23060072_branch_verify_if bus();
    ysyx_23060072_branch_verify #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] pc;
        logic        flag;
        logic [31:0] tgt;
    } rec_t;

    rec_t        mq[$];
    bit          m_rec  = 1'b0;
    logic [31:0] m_rpc  = 32'h0;
    bit          m_serr = 1'b0;
    logic [31:0] m_pctrl = 32'h0;
    logic [31:0] m_pmiss = 32'h0;
    int          total  = 0;
    int          passed = 0;
    int          failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check outputs, then advance the model at posedge.
    task automatic step(input logic r, input logic pv, input logic [31:0] ppc,
                        input logic pf, input logic [31:0] ptg, input logic rv,
                        input logic [31:0] rpc, input logic rt, input logic [31:0] rtg);
        bit          do_push, mis;
        rec_t        h;
        logic [31:0] pn, an;
        @(negedge clk);
        rst = r;
        bus.pred_valid_i = pv; bus.pred_pc_i = ppc; bus.pred_flag_i = pf; bus.pred_target_i = ptg;
        bus.res_valid_i = rv; bus.res_pc_i = rpc; bus.res_taken_i = rt; bus.res_target_i = rtg;
        #1;
        chk("pred_ready", bus.pred_ready_o, (!m_rec && mq.size() < DEPTH));
        chk("res_ready", bus.res_ready_o, (!m_rec && mq.size() > 0));
        chk("redirect", bus.redirect_o, m_rec);
        chk("flush", bus.flush_o, m_rec);
        chk("redirect_pc", bus.redirect_pc_o, m_rpc);
        chk("sync_err", bus.sync_err_o, m_serr);
`ifdef YSYX_23060072_BPU_PERF_EN
        chk("perf_ctrl", bus.perf_ctrl_o, m_pctrl);
        chk("perf_miss", bus.perf_miss_o, m_pmiss);
`endif
        @(posedge clk);
        if (r) begin
            mq.delete(); m_rec = 0; m_rpc = 0; m_serr = 0; m_pctrl = 0; m_pmiss = 0;
        end else if (m_rec) begin
            m_rec = 0;
        end else begin
            do_push = pv && (mq.size() < DEPTH);
            mis = 0;
            if (rv && mq.size() > 0) begin
                h  = mq[0];
                pn = h.flag ? h.tgt : h.pc + 32'd4;
                an = rt ? rtg : rpc + 32'd4;
                if (rpc != h.pc) m_serr = 1;
                if ((h.flag || rt) && m_pctrl != 32'hFFFF_FFFF) m_pctrl++;
                if (pn != an) begin
                    mis = 1;
                    mq.delete();
                    m_rpc = an;
                    m_rec = 1;
                    if (m_pmiss != 32'hFFFF_FFFF) m_pmiss++;
                end else begin
                    void'(mq.pop_front());
                end
            end
            if (do_push && !mis) mq.push_back('{ppc, pf, ptg});
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic push(input logic [31:0] pc, input logic f, input logic [31:0] t);
        step(0, 1, pc, f, t, 0, 0, 0, 0);
    endtask
    task automatic pop(input logic [31:0] pc, input logic tk, input logic [31:0] t);
        step(0, 0, 0, 0, 0, 1, pc, tk, t);
    endtask

    logic        r_rst, r_pv, r_pf, r_rv, r_rt;
    logic [31:0] r_ppc, r_ptg, r_rpc, r_rtg;

    initial begin
        rst = 1'b1;
        bus.pred_valid_i = 0; bus.pred_pc_i = 0; bus.pred_flag_i = 0; bus.pred_target_i = 0;
        bus.res_valid_i = 0; bus.res_pc_i = 0; bus.res_taken_i = 0; bus.res_target_i = 0;
        repeat (2) @(posedge clk);

        // Reset then idle.
        idle(); idle();

        // Correct taken prediction: no redirect, queue drains.
        push(32'h8000_0010, 1, 32'h8000_0000);
        pop(32'h8000_0010, 1, 32'h8000_0000);
        idle();

        // Predicted taken, resolved not taken: redirect to pc+4.
        push(32'h8000_0020, 1, 32'h8000_0000);
        pop(32'h8000_0020, 0, 32'h0);
        idle(); idle();

        // Fill, push against full, then push+pop together; drain in order.
        for (int i = 0; i < DEPTH; i++) push(32'h8000_0100 + 32'(i * 4), 0, 32'h0);
        push(32'h8000_0900, 0, 32'h0);
        step(0, 1, 32'h8000_0200, 0, 32'h0, 1, 32'h8000_0100, 0, 32'h0);
        idle();
        for (int i = 1; i < DEPTH; i++) pop(32'h8000_0100 + 32'(i * 4), 0, 32'h0);
        pop(32'h8000_0200, 0, 32'h0);
        idle();

        // Mispredict pop coinciding with a push: the push is dropped.
        push(32'h8000_0300, 0, 32'h0);
        step(0, 1, 32'h8000_0100, 0, 32'h0, 1, 32'h8000_0300, 1, 32'h8000_0400);
        idle(); idle();

        // Fall-through at the top of the address space wraps to zero.
        push(32'hFFFF_FFFC, 0, 32'h0);
        pop(32'hFFFF_FFFC, 0, 32'h0);
        idle();

        // Reset asserted during RECOVER.
        push(32'h8000_0500, 1, 32'h8000_0600);
        pop(32'h8000_0500, 0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(); idle();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_pv  = $urandom_range(0, 2) != 0;
            r_ppc = {$urandom_range(0, 255), 2'b00} + 32'h8000_0000;
            r_pf  = $urandom_range(0, 1);
            r_ptg = {$urandom_range(0, 255), 2'b00} + 32'h8000_0000;
            r_rv  = $urandom_range(0, 1);
            r_rpc = $urandom;
            r_rt  = $urandom_range(0, 1);
            r_rtg = $urandom;
            if (mq.size() > 0) begin
                if ($urandom_range(0, 19) != 0) r_rpc = mq[0].pc;
                if ($urandom_range(0, 9) < 7) begin
                    r_rt  = mq[0].flag;
                    r_rtg = mq[0].tgt;
                end
            end
            step(r_rst, r_pv, r_ppc, r_pf, r_ptg, r_rv, r_rpc, r_rt, r_rtg);
        end

        // Sticky desync flag: set by a wrong res_pc, held until reset.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        push(32'h8000_0700, 1, 32'h8000_0800);
        pop(32'h8000_0704, 1, 32'h8000_0800);
        idle(); idle();
        push(32'h8000_0710, 0, 32'h0);
        pop(32'h8000_0710, 0, 32'h0);
        idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ysyx_23060072_branch_verify.md
# ysyx_23060072_branch_verify

Execute-side counterpart of the IF-stage static predictor; closes the loop the predictor opens. Records every prediction IF makes in a small in-order queue and compares it against the outcome EX resolves. On a wrong next-PC it issues a registered redirect with the correct PC and a pipeline flush. Sits between IF (push side) and EX (pop side).

## Interface
- DEPTH, 4: prediction queue entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pred_valid_i  in  1  IF pushes one record per fetched instruction.
- pred_ready_o  out  1  queue can accept a record.
- pred_pc_i  in  32  fetch PC.
- pred_flag_i  in  1  predictor said taken.
- pred_target_i  in  32  predicted target; meaningful only when pred_flag_i=1.
- res_valid_i  in  1  EX resolves one instruction, in program order.
- res_ready_o  out  1  head record available to consume.
- res_pc_i  in  32  PC of resolved instruction.
- res_taken_i  in  1  actual control transfer taken (branch/jal/jalr).
- res_target_i  in  32  actual target; meaningful only when res_taken_i=1.
- redirect_o  out  1  one-cycle pulse: fetch must restart at redirect_pc_o.
- redirect_pc_o  out  32  correct next PC.
- flush_o  out  1  kill all younger in-flight instructions; same cycle as redirect_o.
- sync_err_o  out  1  sticky: res_pc_i differed from head PC.

## Operation
- Queue: circular buffer, read/write pointers log2(DEPTH)+1 bits (extra wrap bit); full = indices equal and wrap bits differ; empty = pointers equal.
- Push when pred_valid_i & pred_ready_o; pop when res_valid_i & res_ready_o.
- pred_ready_o = !full & state==RUN; no same-cycle bypass when full. res_ready_o = !empty & state==RUN.
- Per pop: pred_next = flag ? target : pc+4; act_next = res_taken_i ? res_target_i : res_pc_i+4. Additions modulo 2^32.
- Mismatch iff pred_next != act_next. Covers taken-backward branch that falls through, forward branch taken, any taken jalr (predictor never predicts it).
- States: RUN, RECOVER.
  - RUN, pop with mismatch: register redirect_pc_o=act_next, clear queue (both pointers to 0), drop any same-cycle push (wrong path), go RECOVER.
  - RECOVER: redirect_o=flush_o=1 for exactly this cycle; both readies 0; next cycle RUN.
- Pop with res_pc_i != head PC sets sync_err_o (cleared only by rst); comparison still proceeds on head record.
- Simultaneous push and pop in RUN without mismatch: both take effect; count unchanged.

## Timing
- Reset: state RUN, pointers 0, redirect_o=0, flush_o=0, redirect_pc_o=0, sync_err_o=0, pred_ready_o=1, res_ready_o=0.
- Resolve-to-redirect latency: 1 cycle (mispredicting pop at edge N → redirect_o high during cycle N+1).
- Push-to-poppable latency: 1 cycle (record visible at head the cycle after push).
- First push accepted again the cycle after RECOVER.
- rst asserted in RECOVER: next cycle is reset state, no redirect pulse.

## Configuration
- YSYX_23060072_BPU_PERF_EN defined: adds 32-bit saturating counters perf_ctrl_o (pops with pred_flag or res_taken), perf_miss_o (mismatches), output ports; reset to 0; saturate at 0xFFFF_FFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared define file: state encodings RUN/RECOVER, instruction size constant 4, enable/disable constants already in use.
- One sub-module: ysyx_23060072_pred_fifo (parameterised circular queue, 65-bit entries {pc, flag, target}, full/empty flags, sync clear). Compare/FSM/counters in top.

## Test plan
- Reset then idle: all outputs at reset values; pred_ready_o=1, res_ready_o=0.
- Push {0x8000_0010, flag=1, 0x8000_0000}; resolve pc 0x8000_0010 taken 0x8000_0000 → no redirect, queue empty after.
- Push {0x8000_0020, flag=1, 0x8000_0000}; resolve not taken → redirect_o pulse next cycle, redirect_pc_o=0x8000_0024, flush_o=1, readies 0 one cycle.
- Push four records (DEPTH=4): pred_ready_o=0 after fourth; pop one with push held → push accepted following cycle; order preserved.
- Mismatch pop coinciding with push of 0x8000_0100 → that record dropped; queue empty after RECOVER.
- Resolve pc 0xFFFF_FFFC not taken vs pred_flag=0: pred_next=act_next=0x0000_0000, no redirect; resolve with res_pc_i≠head → sync_err_o stays 1 until rst.
